stream_feeder: RTL

- Host-side transmitter for the accelerator's con_valid/con_ready load interface; it is the sending end of the stream that the device controller consumes.
- Fetches kernel and feature-map words from two synchronous read memories and sends them in the order the controller loads them:
  - per output-channel group: the kernel words;
  - then per row: the preload words, followed by COLUMN_WORDS words for each x.
- A 2-entry output buffer absorbs the 1-cycle memory latency so the stream runs at full rate under backpressure.

---
 rtl/stream_feeder.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/stream_feeder.sv
// Host-side streamer: fetches kernel and feature-map words from two synchronous
// read memories and sends them in controller load order over con_valid/con_ready.
module stream_feeder #(
    parameter int DATA_WIDTH         = 16,
    parameter int ADDR_WIDTH         = 20,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int NB_GROUPS          = 11,
    parameter int KERNEL_WORDS       = 72,
    parameter int PRELOAD_WORDS      = 12,
    parameter int COLUMN_WORDS       = 4
) (
    input  logic                  clk,
    input  logic                  arst_in,
    input  logic                  start,
    output logic                  running,
    output logic                  done,
    output logic                  con_valid,
    input  logic                  con_ready,
    output logic [DATA_WIDTH-1:0] con_data,
    output logic                  kmem_re,
    output logic [ADDR_WIDTH-1:0] kmem_addr,
    input  logic [DATA_WIDTH-1:0] kmem_rdata,
    output logic                  fmem_re,
    output logic [ADDR_WIDTH-1:0] fmem_addr,
    input  logic [DATA_WIDTH-1:0] fmem_rdata,
    output logic [31:0]           cur_group
);

    typedef enum logic [2:0] {IDLE, KERNEL, PRELOAD, COLUMN, DRAIN} state_t;

    localparam logic [31:0] KW_LAST = 32'(KERNEL_WORDS - 1);
    localparam logic [31:0] PW_LAST = 32'(PRELOAD_WORDS - 1);
    localparam logic [31:0] CW_LAST = 32'(COLUMN_WORDS - 1);
    localparam logic [31:0] X_LAST  = 32'(FEATURE_MAP_WIDTH - 1);
    localparam logic [31:0] Y_LAST  = 32'(FEATURE_MAP_HEIGHT - 1);
    localparam logic [31:0] G_LAST  = 32'(NB_GROUPS - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                state_q, state_d;
    logic [31:0]           groupCnt_q, groupCnt_d;
    logic [31:0]           rowCnt_q, rowCnt_d;
    logic [31:0]           colCnt_q, colCnt_d;
    logic [31:0]           wordCnt_q, wordCnt_d;
    logic [ADDR_WIDTH-1:0] kAddr_q, kAddr_d;
    logic [ADDR_WIDTH-1:0] fAddr_q, fAddr_d;

    logic [DATA_WIDTH-1:0] bufHead_q, bufHead_d;
    logic [DATA_WIDTH-1:0] bufTail_q, bufTail_d;
    logic [1:0]            bufCount_q, bufCount_d;
    logic                  inFlight_q, inFlight_d;
    logic                  inFlightKern_q, inFlightKern_d;

    logic                  pop;
    logic [2:0]            occupancy;
    logic                  canIssue;
    logic [DATA_WIDTH-1:0] pushData;

    assign con_valid = (bufCount_q != 2'd0);
    assign con_data  = bufHead_q;
    assign pop       = con_valid && con_ready;
    assign running   = (state_q != IDLE);
    assign cur_group = groupCnt_q;
    assign kmem_addr = kAddr_q;
    assign fmem_addr = fAddr_q;

    // A read issued now lands next cycle, so it must fit after this cycle's pop.
    assign occupancy = {1'b0, bufCount_q} + {2'b00, inFlight_q} - {2'b00, pop};
    assign canIssue  = (occupancy < 3'd2);

    always_comb begin
        state_d    = state_q;
        groupCnt_d = groupCnt_q;
        rowCnt_d   = rowCnt_q;
        colCnt_d   = colCnt_q;
        wordCnt_d  = wordCnt_q;
        kAddr_d    = kAddr_q;
        fAddr_d    = fAddr_q;
        kmem_re    = 1'b0;
        fmem_re    = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = KERNEL;
                    groupCnt_d = '0;
                    rowCnt_d   = '0;
                    colCnt_d   = '0;
                    wordCnt_d  = '0;
                    kAddr_d    = '0;
                    fAddr_d    = '0;
                end
            end
            KERNEL: begin
                if (canIssue) begin
                    kmem_re = 1'b1;
                    kAddr_d = kAddr_q + ADDR_ONE;
                    if (wordCnt_q != KW_LAST) begin
                        wordCnt_d = wordCnt_q + 32'd1;
                    end else begin
                        wordCnt_d = '0;
                        state_d   = PRELOAD;
                    end
                end
            end
            PRELOAD: begin
                if (canIssue) begin
                    fmem_re = 1'b1;
                    fAddr_d = fAddr_q + ADDR_ONE;
                    if (wordCnt_q != PW_LAST) begin
                        wordCnt_d = wordCnt_q + 32'd1;
                    end else begin
                        wordCnt_d = '0;
                        colCnt_d  = '0;
                        state_d   = COLUMN;
                    end
                end
            end
            COLUMN: begin
                if (canIssue) begin
                    fmem_re = 1'b1;
                    fAddr_d = fAddr_q + ADDR_ONE;
                    if (wordCnt_q != CW_LAST) begin
                        wordCnt_d = wordCnt_q + 32'd1;
                    end else begin
                        wordCnt_d = '0;
                        if (colCnt_q != X_LAST) begin
                            colCnt_d = colCnt_q + 32'd1;
                        end else if (rowCnt_q != Y_LAST) begin
                            rowCnt_d = rowCnt_q + 32'd1;
                            state_d  = PRELOAD;
                        end else if (groupCnt_q != G_LAST) begin
                            // Feature map is resent per group; kernel address keeps running.
                            groupCnt_d = groupCnt_q + 32'd1;
                            rowCnt_d   = '0;
                            fAddr_d    = '0;
                            state_d    = KERNEL;
                        end else begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (bufCount_q == 2'd0 && !inFlight_q) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bufHead_d      = bufHead_q;
        bufTail_d      = bufTail_q;
        bufCount_d     = bufCount_q;
        inFlight_d     = kmem_re | fmem_re;
        inFlightKern_d = kmem_re;
        pushData       = inFlightKern_q ? kmem_rdata : fmem_rdata;
        unique case ({inFlight_q, pop})
            2'b10: begin
                if (bufCount_q == 2'd0) bufHead_d = pushData;
                else                    bufTail_d = pushData;
                bufCount_d = bufCount_q + 2'd1;
            end
            2'b01: begin
                bufHead_d  = bufTail_q;
                bufCount_d = bufCount_q - 2'd1;
            end
            2'b11: begin
                if (bufCount_q == 2'd1) begin
                    bufHead_d = pushData;
                end else begin
                    bufHead_d = bufTail_q;
                    bufTail_d = pushData;
                end
            end
            default: ;
        endcase
    end

    // Reset drops any read in flight and everything buffered.
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            state_q        <= IDLE;
            groupCnt_q     <= '0;
            rowCnt_q       <= '0;
            colCnt_q       <= '0;
            wordCnt_q      <= '0;
            kAddr_q        <= '0;
            fAddr_q        <= '0;
            bufHead_q      <= '0;
            bufTail_q      <= '0;
            bufCount_q     <= '0;
            inFlight_q     <= 1'b0;
            inFlightKern_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            groupCnt_q     <= groupCnt_d;
            rowCnt_q       <= rowCnt_d;
            colCnt_q       <= colCnt_d;
            wordCnt_q      <= wordCnt_d;
            kAddr_q        <= kAddr_d;
            fAddr_q        <= fAddr_d;
            bufHead_q      <= bufHead_d;
            bufTail_q      <= bufTail_d;
            bufCount_q     <= bufCount_d;
            inFlight_q     <= inFlight_d;
            inFlightKern_q <= inFlightKern_d;
        end
    end

endmodule
